// File: rtl/deck_mem_arbiter_if.sv
// Deck memory arbiter bundle: three requesters (loader, shuffler, draw) plus the memory port.
// The arbiter takes the slave modport; the requester/memory environment takes master.
interface deck_mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 7
);
  logic              req_l, req_s, req_d;
  logic              lock_l, lock_s, lock_d;
  logic              wen_l, wen_s, wen_d;
  logic [ADDR_W-1:0] addr_l, addr_s, addr_d;
  logic [DATA_W-1:0] wdata_l, wdata_s, wdata_d;
  logic              gnt_l, gnt_s, gnt_d;
  logic              rvalid_l, rvalid_s, rvalid_d;
  logic [DATA_W-1:0] rdata_l, rdata_s, rdata_d;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_in, mem_out;

  modport slave (
    input  req_l, req_s, req_d, lock_l, lock_s, lock_d, wen_l, wen_s, wen_d,
    input  addr_l, addr_s, addr_d, wdata_l, wdata_s, wdata_d, mem_out,
    output gnt_l, gnt_s, gnt_d, rvalid_l, rvalid_s, rvalid_d,
    output rdata_l, rdata_s, rdata_d, mem_addr, mem_wen, mem_in
  );

  modport master (
    output req_l, req_s, req_d, lock_l, lock_s, lock_d, wen_l, wen_s, wen_d,
    output addr_l, addr_s, addr_d, wdata_l, wdata_s, wdata_d, mem_out,
    input  gnt_l, gnt_s, gnt_d, rvalid_l, rvalid_s, rvalid_d,
    input  rdata_l, rdata_s, rdata_d, mem_addr, mem_wen, mem_in
  );
endinterface

// File: rtl/deck_mem_arbiter.sv
// Deck memory arbiter: loader-only INIT phase, then shuffler/draw round-robin.
// Define DECK_ARB_LOCK_EN to build the LOCKED state with its hold watchdog and busy flag.
module deck_mem_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 7,
  parameter int LOCK_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_done,
  output logic               busy,
  deck_mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {INIT, RUN, LOCKED} state_t;
  localparam logic P_S = 1'b0;
  localparam logic P_D = 1'b1;

  state_t     state, state_nxt;
  logic       ptr, ptr_nxt;
  logic       gnt_l, gnt_s, gnt_d;
  logic       who;
  logic [2:0] rd_pend;
  logic       unused_lock;

`ifdef DECK_ARB_LOCK_EN
  localparam int WD_W = $clog2(LOCK_MAX + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(LOCK_MAX);
  logic [WD_W-1:0] wd, wd_nxt;
  logic            owner, owner_nxt;
  // blk/blk_who: watchdog-evicted owner may not re-lock until it drops lock once
  logic            blk, blk_nxt, blk_who, blk_who_nxt;
  logic            lk_gnt, lk_own, lk_blk;
  assign unused_lock = bus.lock_l;
  assign busy        = (state == LOCKED);
`else
  assign unused_lock = ^{bus.lock_l, bus.lock_s, bus.lock_d};
  assign busy        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      ptr     <= P_S;
      rd_pend <= '0;
`ifdef DECK_ARB_LOCK_EN
      wd      <= '0;
      owner   <= P_S;
      blk     <= 1'b0;
      blk_who <= P_S;
`endif
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      rd_pend <= {gnt_d & ~bus.wen_d, gnt_s & ~bus.wen_s, gnt_l & ~bus.wen_l};
`ifdef DECK_ARB_LOCK_EN
      wd      <= wd_nxt;
      owner   <= owner_nxt;
      blk     <= blk_nxt;
      blk_who <= blk_who_nxt;
`endif
    end
  end

  assign who = gnt_d;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
`ifdef DECK_ARB_LOCK_EN
    wd_nxt      = wd;
    owner_nxt   = owner;
    blk_nxt     = blk;
    blk_who_nxt = blk_who;
    lk_gnt      = who ? bus.lock_d : bus.lock_s;
    lk_own      = owner ? bus.lock_d : bus.lock_s;
    lk_blk      = blk_who ? bus.lock_d : bus.lock_s;
    if (blk && !lk_blk) blk_nxt = 1'b0;
`endif
    unique case (state)
      INIT: if (load_done) state_nxt = RUN;
      RUN: if (gnt_s || gnt_d) begin
        ptr_nxt = ~who;
`ifdef DECK_ARB_LOCK_EN
        if (lk_gnt && !(blk && blk_who == who)) begin
          state_nxt = LOCKED;
          ptr_nxt   = ptr;
          owner_nxt = who;
          wd_nxt    = WD_W'(1);
        end
`endif
      end
`ifdef DECK_ARB_LOCK_EN
      LOCKED: begin
        if (!lk_own || wd == WD_MAX) begin
          state_nxt = RUN;
          ptr_nxt   = ~owner;
          wd_nxt    = '0;
          if (lk_own) begin
            blk_nxt     = 1'b1;
            blk_who_nxt = owner;
          end
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
`endif
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    gnt_l = 1'b0;
    gnt_s = 1'b0;
    gnt_d = 1'b0;
    if (!rst) begin
      unique case (state)
        INIT: gnt_l = bus.req_l;
        RUN: begin
          if (bus.req_s && bus.req_d) begin
            gnt_s = (ptr == P_S);
            gnt_d = (ptr == P_D);
          end else begin
            gnt_s = bus.req_s;
            gnt_d = bus.req_d;
          end
        end
`ifdef DECK_ARB_LOCK_EN
        LOCKED: begin
          gnt_s = bus.req_s && (owner == P_S);
          gnt_d = bus.req_d && (owner == P_D);
        end
`endif
        default: ;
      endcase
    end
    bus.mem_wen  = 1'b0;
    bus.mem_addr = '0;
    bus.mem_in   = '0;
    if (gnt_l) begin
      bus.mem_wen = bus.wen_l; bus.mem_addr = bus.addr_l; bus.mem_in = bus.wdata_l;
    end else if (gnt_s) begin
      bus.mem_wen = bus.wen_s; bus.mem_addr = bus.addr_s; bus.mem_in = bus.wdata_s;
    end else if (gnt_d) begin
      bus.mem_wen = bus.wen_d; bus.mem_addr = bus.addr_d; bus.mem_in = bus.wdata_d;
    end
  end

  assign bus.gnt_l    = gnt_l;
  assign bus.gnt_s    = gnt_s;
  assign bus.gnt_d    = gnt_d;
  assign bus.rvalid_l = rd_pend[0];
  assign bus.rvalid_s = rd_pend[1];
  assign bus.rvalid_d = rd_pend[2];
  assign bus.rdata_l  = rd_pend[0] ? bus.mem_out : '0;
  assign bus.rdata_s  = rd_pend[1] ? bus.mem_out : '0;
  assign bus.rdata_d  = rd_pend[2] ? bus.mem_out : '0;
endmodule

// File: tb/tb_deck_mem_arbiter.sv
// Directed bench for deck_mem_arbiter: INIT write, round-robin, read latency,
// lock/watchdog when DECK_ARB_LOCK_EN is defined, and reset during activity.
module tb_deck_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic load_done;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] ram [64];

  deck_mem_arbiter_if #(.ADDR_W(6), .DATA_W(7)) bus ();

  deck_mem_arbiter #(.ADDR_W(6), .DATA_W(7), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst), .load_done(load_done), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  // synchronous RAM standing in for the deck memory
  always @(posedge clk) begin
    if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_in;
    bus.mem_out <= ram[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load_done = 1'b0;
    bus.req_l = 1'b1; bus.lock_l = 1'b0; bus.wen_l = 1'b1; bus.addr_l = 6'd5; bus.wdata_l = 7'h2A;
    bus.req_s = 1'b0; bus.lock_s = 1'b0; bus.wen_s = 1'b0; bus.addr_s = 6'd0; bus.wdata_s = 7'h00;
    bus.req_d = 1'b1; bus.lock_d = 1'b0; bus.wen_d = 1'b0; bus.addr_d = 6'd0; bus.wdata_d = 7'h00;
    #2;
    chk("rst_gnt_l", bus.gnt_l, 0);
    chk("rst_gnt_d", bus.gnt_d, 0);
    chk("rst_mem_wen", bus.mem_wen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid_l", bus.rvalid_l, 0);
    chk("rst_rdata_d", bus.rdata_d, 0);

    nxt(); rst = 1'b0; #2;
    chk("init_gnt_l", bus.gnt_l, 1);
    chk("init_gnt_d", bus.gnt_d, 0);
    chk("init_mem_wen", bus.mem_wen, 1);
    chk("init_mem_addr", bus.mem_addr, 5);
    chk("init_mem_in", bus.mem_in, 7'h2A);

    nxt(); bus.req_l = 1'b0; load_done = 1'b1; #2;
    chk("wr_no_rvalid_l", bus.rvalid_l, 0);
    chk("init_still_gnt_d", bus.gnt_d, 0);

    nxt(); load_done = 1'b0;
    bus.req_l = 1'b1; bus.wen_l = 1'b0;
    bus.req_s = 1'b1; bus.addr_s = 6'd1; bus.req_d = 1'b1; bus.addr_d = 6'd2;
    #2;
    for (int i = 0; i < 4; i++) begin
      chk("rr_gnt_s", bus.gnt_s, (i % 2 == 0) ? 1 : 0);
      chk("rr_gnt_d", bus.gnt_d, (i % 2 == 1) ? 1 : 0);
      chk("rr_gnt_l", bus.gnt_l, 0);
      nxt(); #2;
    end

    bus.req_l = 1'b0; bus.req_s = 1'b0; bus.addr_d = 6'd5;
    #1;
    chk("solo_gnt_d", bus.gnt_d, 1);
    chk("solo_mem_addr", bus.mem_addr, 5);
    nxt(); bus.req_d = 1'b0; #2;
    chk("rd_rvalid_d", bus.rvalid_d, 1);
    chk("rd_rdata_d", bus.rdata_d, 7'h2A);
    chk("rd_rvalid_s", bus.rvalid_s, 0);
    chk("rd_rdata_s", bus.rdata_s, 0);
    chk("idle_mem_wen", bus.mem_wen, 0);
    chk("idle_mem_addr", bus.mem_addr, 0);

`ifdef DECK_ARB_LOCK_EN
    nxt(); bus.req_s = 1'b1; bus.req_d = 1'b1; bus.lock_s = 1'b1; bus.addr_s = 6'd5; #2;
    chk("lk_first_gnt_s", bus.gnt_s, 1);
    chk("lk_first_busy", busy, 0);
    for (int i = 0; i < 2; i++) begin
      nxt(); #2;
      chk("lk_hold_gnt_s", bus.gnt_s, 1);
      chk("lk_hold_gnt_d", bus.gnt_d, 0);
      chk("lk_hold_busy", busy, 1);
    end
    nxt(); bus.lock_s = 1'b0; #2;
    chk("lk_rel_gnt_s", bus.gnt_s, 1);
    chk("lk_rel_busy", busy, 1);
    nxt(); #2;
    chk("lk_after_gnt_d", bus.gnt_d, 1);
    chk("lk_after_busy", busy, 0);

    nxt(); bus.lock_s = 1'b1; #2;
    chk("wd_entry_gnt_s", bus.gnt_s, 1);
    for (int k = 1; k <= 8; k++) begin
      nxt(); #2;
      chk("wd_hold_gnt_s", bus.gnt_s, 1);
      chk("wd_hold_busy", busy, 1);
    end
    nxt(); #2;
    chk("wd_forced_gnt_d", bus.gnt_d, 1);
    chk("wd_forced_busy", busy, 0);
    nxt(); #2;
    chk("wd_blocked_gnt_s", bus.gnt_s, 1);
    nxt(); bus.lock_s = 1'b0; #2;
    chk("wd_no_relock_busy", busy, 0);
    chk("wd_no_relock_gnt_d", bus.gnt_d, 1);
    nxt(); bus.lock_s = 1'b1; #2;
    chk("relock_gnt_s", bus.gnt_s, 1);
    nxt(); #2;
    chk("relock_busy", busy, 1);
    chk("relock_rvalid_s", bus.rvalid_s, 1);
`else
    nxt(); bus.req_s = 1'b1; bus.req_d = 1'b1; bus.lock_s = 1'b1; bus.addr_s = 6'd5; #2;
    chk("nolk_gnt_s", bus.gnt_s, 1);
    chk("nolk_busy", busy, 0);
    nxt(); #2;
    chk("nolk_next_gnt_d", bus.gnt_d, 1);
    chk("nolk_next_busy", busy, 0);
    chk("nolk_rvalid_s", bus.rvalid_s, 1);
`endif

    rst = 1'b1; #1;
    chk("midrst_gnt_s", bus.gnt_s, 0);
    chk("midrst_gnt_d", bus.gnt_d, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_wen", bus.mem_wen, 0);
    chk("midrst_rvalid_s", bus.rvalid_s, 0);
    nxt(); rst = 1'b0; #2;
    chk("post_rst_rvalid_s", bus.rvalid_s, 0);
    chk("post_rst_gnt_s", bus.gnt_s, 0);
    chk("post_rst_gnt_d", bus.gnt_d, 0);
    chk("post_rst_busy", busy, 0);
    nxt(); load_done = 1'b1; #2;
    chk("post_rst_init_gnt_d", bus.gnt_d, 0);
    nxt(); load_done = 1'b0; #2;
    chk("post_load_gnt_s", bus.gnt_s, 1);
    chk("post_load_gnt_d", bus.gnt_d, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
